// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART receive frame decode (5-8 data bits, parity, 1/2 stop) with tagged output FIFO.
// Optional break detection is compiled in with `define UART_RX_BREAK_DETECT_EN.
module uart_rx_frame_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int AFULL_LVL  = FIFO_DEPTH - 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [11:0]                   parallel_data_rx,
    input  logic [4:0]                    line_control_reg,
    input  logic                          received_flag,
    input  logic                          rx_ready,
    input  logic                          clear_overrun,
    output logic [7:0]                    data_received,
    output logic                          rx_valid,
    output logic                          rx_perr,
    output logic                          rx_ferr,
    output logic                          rx_brk,
    output logic                          data_corrupted_flag,
    output logic                          transmission_done_flag,
    output logic                          start_err,
    output logic                          overrun_flag,
    output logic                          rx_afull,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 11;

    logic        flag_q;
    logic        cap_valid;
    logic [11:0] cap_frame;
    logic [4:0]  cap_lcr;

    logic        dec_push;
    logic [7:0]  dec_data;
    logic        dec_perr;
    logic        dec_ferr;
    logic        dec_brk;

    logic [3:0]  word_len;
    logic [3:0]  par_pos;
    logic [3:0]  stop1_pos;
    logic [3:0]  stop2_pos;
    logic [3:0]  last_pos;
    logic [7:0]  dat_c;
    logic [11:0] used_mask;
    logic        par_x;
    logic        perr_c;
    logic        ferr_c;
    logic        brk_c;

    // Field positions follow from word length and which optional bits are present.
    always_comb begin
        word_len  = {2'b00, cap_lcr[1:0]} + 4'd5;
        par_pos   = word_len + 4'd1;
        stop1_pos = par_pos + {3'b000, cap_lcr[3]};
        stop2_pos = stop1_pos + 4'd1;
        last_pos  = cap_lcr[2] ? stop2_pos : stop1_pos;
        dat_c     = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < word_len) dat_c[i] = cap_frame[i+1];
        end
        used_mask = '0;
        for (int i = 0; i < 12; i++) begin
            if (4'(i) <= last_pos) used_mask[i] = 1'b1;
        end
        par_x  = (^dat_c) ^ cap_frame[par_pos];
        perr_c = cap_lcr[3] & (par_x ^ ~cap_lcr[4]);
        ferr_c = ~cap_frame[stop1_pos] | (cap_lcr[2] & ~cap_frame[stop2_pos]);
`ifdef UART_RX_BREAK_DETECT_EN
        brk_c  = ~|(cap_frame & used_mask);
`else
        brk_c  = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q    <= 1'b0;
            cap_valid <= 1'b0;
            cap_frame <= '0;
            cap_lcr   <= '0;
            dec_push  <= 1'b0;
            dec_data  <= '0;
            dec_perr  <= 1'b0;
            dec_ferr  <= 1'b0;
            dec_brk   <= 1'b0;
            start_err <= 1'b0;
        end else begin
            flag_q    <= received_flag;
            cap_valid <= received_flag & ~flag_q;
            cap_frame <= parallel_data_rx;
            cap_lcr   <= line_control_reg;
            dec_push  <= cap_valid & ~cap_frame[0];
            start_err <= cap_valid & cap_frame[0];
            dec_data  <= brk_c ? 8'h00 : dat_c;
            dec_perr  <= perr_c & ~brk_c;
            dec_ferr  <= ferr_c & ~brk_c;
            dec_brk   <= brk_c;
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [EW-1:0] head;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = ~empty & rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push  = dec_push & (~full | pop);
    assign drop  = dec_push & full & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr                 <= '0;
            rd_ptr                 <= '0;
            transmission_done_flag <= 1'b0;
            overrun_flag           <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            transmission_done_flag <= push;
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= {dec_data, dec_perr, dec_ferr, dec_brk};
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (drop) overrun_flag <= 1'b1;
            else if (clear_overrun) overrun_flag <= 1'b0;
        end
    end

    assign head                = mem[rd_ptr[AW-1:0]];
    assign data_received       = head[10:3];
    assign rx_perr             = head[2];
    assign rx_ferr             = head[1];
    assign rx_brk              = head[0];
    assign rx_valid            = ~empty;
    assign data_corrupted_flag = rx_valid & (rx_perr | rx_ferr | rx_brk);
    assign fifo_level          = wr_ptr - rd_ptr;
    assign rx_afull            = (fifo_level >= LW'(AFULL_LVL));

endmodule
